// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register and writeback logic for the RV32I core.
// Captures the memory-stage outputs, aligns and extends load data, selects the
// writeback value for the register file and forwarding, and counts retired
// instructions.
module writeback_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_w_i,
  input  logic             flush_w_i,
  input  logic             valid_m_i,
  input  logic             reg_write_m_i,
  input  logic [1:0]       result_src_m_i,
  input  logic [2:0]       funct3_m_i,
  input  logic [4:0]       rd_m_i,
  input  logic [WIDTH-1:0] alu_result_m_i,
  input  logic [WIDTH-1:0] read_data_m_i,
  input  logic [WIDTH-1:0] pc_plus_4_m_i,
  output logic             reg_write_w_o,
  output logic [4:0]       rd_w_o,
  output logic [WIDTH-1:0] result_w_o,
  output logic             valid_w_o,
  output logic [63:0]      instret_o
);

  localparam int NUM_BYTES = WIDTH / 8;

  // Result select encodings.
  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  // Load size/sign encodings (funct3).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // W register fields.
  logic             valid_reg;
  logic             reg_write_reg;
  logic [1:0]       result_src_reg;
  logic [2:0]       funct3_reg;
  logic [4:0]       rd_reg;
  logic [WIDTH-1:0] alu_result_reg;
  logic [WIDTH-1:0] read_data_reg;
  logic [WIDTH-1:0] pc_plus_4_reg;
  logic [1:0]       addr_lo_reg;
  logic [63:0]      instret_reg;

  // Next-state values.
  logic             load_en;
  logic             valid_next;
  logic             reg_write_next;
  logic [63:0]      instret_next;

  // Load extraction intermediates.
  logic [7:0]       byte_lane [NUM_BYTES];
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] result_mux;

  // Flush takes priority over stall; fields other than valid/reg_write are
  // don't-care on a flush, so they simply load along with everything else.
  always_comb begin
    load_en        = flush_w_i || !stall_w_i;
    valid_next     = valid_reg;
    reg_write_next = reg_write_reg;
    instret_next   = instret_reg;
    if (flush_w_i) begin
      valid_next     = 1'b0;
      reg_write_next = 1'b0;
    end else if (!stall_w_i) begin
      valid_next     = valid_m_i;
      reg_write_next = reg_write_m_i;
      if (valid_m_i) begin
        // Wraps modulo 2^64 naturally.
        instret_next = instret_reg + 64'd1;
      end
    end
  end

  // Control bits and retired counter; asynchronous reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      reg_write_reg <= 1'b0;
      instret_reg   <= 64'd0;
    end else begin
      valid_reg     <= valid_next;
      reg_write_reg <= reg_write_next;
      instret_reg   <= instret_next;
    end
  end

  // Datapath fields of the W register: load on flush or when not stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_src_reg <= 2'b00;
      funct3_reg     <= 3'b000;
      rd_reg         <= 5'd0;
      alu_result_reg <= '0;
      read_data_reg  <= '0;
      pc_plus_4_reg  <= '0;
      addr_lo_reg    <= 2'b00;
    end else if (load_en) begin
      result_src_reg <= result_src_m_i;
      funct3_reg     <= funct3_m_i;
      rd_reg         <= rd_m_i;
      alu_result_reg <= alu_result_m_i;
      read_data_reg  <= read_data_m_i;
      pc_plus_4_reg  <= pc_plus_4_m_i;
      addr_lo_reg    <= alu_result_m_i[1:0];
    end
  end

  // Split the raw word into little-endian byte lanes.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_lane
      assign byte_lane[gi] = read_data_reg[8*gi +: 8];
    end
  endgenerate

  // Pick the addressed byte and halfword.
  always_comb begin
    sel_byte = byte_lane[addr_lo_reg];
    sel_half = addr_lo_reg[1] ? read_data_reg[31:16] : read_data_reg[15:0];
  end

  // Size/sign extension; unknown encodings fall back to the full word.
  always_comb begin
    load_data = read_data_reg;
    case (funct3_reg)
      F3_LB:   load_data = {{(WIDTH-8){sel_byte[7]}}, sel_byte};
      F3_LBU:  load_data = {{(WIDTH-8){1'b0}}, sel_byte};
      F3_LH:   load_data = {{(WIDTH-16){sel_half[15]}}, sel_half};
      F3_LHU:  load_data = {{(WIDTH-16){1'b0}}, sel_half};
      default: load_data = read_data_reg;
    endcase
  end

  // Writeback result select from the registered control.
  always_comb begin
    result_mux = '0;
    case (result_src_reg)
      SRC_ALU:  result_mux = alu_result_reg;
      SRC_LOAD: result_mux = load_data;
      SRC_PC4:  result_mux = pc_plus_4_reg;
      default:  result_mux = '0;
    endcase
  end

  // Outputs come straight from the W register; x0 writes are dropped here.
  assign reg_write_w_o = valid_reg && reg_write_reg && (rd_reg != 5'd0);
  assign rd_w_o        = rd_reg;
  assign result_w_o    = result_mux;
  assign valid_w_o     = valid_reg;
  assign instret_o     = instret_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed table-driven bench for writeback_stage, plus
// hand-written sequences for stall, flush, asynchronous reset and counter wrap.
`timescale 1ns/1ps
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        stall_w_i;
  logic        flush_w_i;
  logic        valid_m_i;
  logic        reg_write_m_i;
  logic [1:0]  result_src_m_i;
  logic [2:0]  funct3_m_i;
  logic [4:0]  rd_m_i;
  logic [31:0] alu_result_m_i;
  logic [31:0] read_data_m_i;
  logic [31:0] pc_plus_4_m_i;
  logic        reg_write_w_o;
  logic [4:0]  rd_w_o;
  logic [31:0] result_w_o;
  logic        valid_w_o;
  logic [63:0] instret_o;

  int tests_run = 0;
  int tests_failed = 0;

  writeback_stage #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_w_i      (stall_w_i),
    .flush_w_i      (flush_w_i),
    .valid_m_i      (valid_m_i),
    .reg_write_m_i  (reg_write_m_i),
    .result_src_m_i (result_src_m_i),
    .funct3_m_i     (funct3_m_i),
    .rd_m_i         (rd_m_i),
    .alu_result_m_i (alu_result_m_i),
    .read_data_m_i  (read_data_m_i),
    .pc_plus_4_m_i  (pc_plus_4_m_i),
    .reg_write_w_o  (reg_write_w_o),
    .rd_w_o         (rd_w_o),
    .result_w_o     (result_w_o),
    .valid_w_o      (valid_w_o),
    .instret_o      (instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        rw;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic        exp_rw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_res;
    logic        exp_valid;
    logic [63:0] exp_instret;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_rw, input logic [4:0] e_rd,
                           input logic [31:0] e_res, input logic e_valid, input logic [63:0] e_ir);
    check({tag, ".reg_write"}, {63'd0, reg_write_w_o}, {63'd0, e_rw});
    check({tag, ".rd"},        {59'd0, rd_w_o},        {59'd0, e_rd});
    check({tag, ".result"},    {32'd0, result_w_o},    {32'd0, e_res});
    check({tag, ".valid"},     {63'd0, valid_w_o},     {63'd0, e_valid});
    check({tag, ".instret"},   instret_o,              e_ir);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4);
    valid_m_i      = v;
    reg_write_m_i  = rw;
    result_src_m_i = src;
    funct3_m_i     = f3;
    rd_m_i         = rd;
    alu_result_m_i = alu;
    read_data_m_i  = rdata;
    pc_plus_4_m_i  = pc4;
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                name      v     rw    src    f3      rd    alu           rdata         pc4           erw   erd   eres          ev    einstret
    vecs[0]  = '{"alu",      1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 32'hDEAD_BEEF, 32'h0,        32'h0,        1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 64'd1};
    vecs[1]  = '{"lb_101",   1'b1, 1'b1, 2'b01, 3'b000, 5'd4, 32'h0000_0101, 32'h807F_F1A2, 32'h0,       1'b1, 5'd4, 32'hFFFF_FFF1, 1'b1, 64'd2};
    vecs[2]  = '{"lbu_103",  1'b1, 1'b1, 2'b01, 3'b100, 5'd4, 32'h0000_0103, 32'h807F_F1A2, 32'h0,       1'b1, 5'd4, 32'h0000_0080, 1'b1, 64'd3};
    vecs[3]  = '{"lh_102",   1'b1, 1'b1, 2'b01, 3'b001, 5'd5, 32'h0000_0102, 32'h807F_F1A2, 32'h0,       1'b1, 5'd5, 32'hFFFF_807F, 1'b1, 64'd4};
    vecs[4]  = '{"lhu_100",  1'b1, 1'b1, 2'b01, 3'b101, 5'd6, 32'h0000_0100, 32'h807F_F1A2, 32'h0,       1'b1, 5'd6, 32'h0000_F1A2, 1'b1, 64'd5};
    vecs[5]  = '{"lw",       1'b1, 1'b1, 2'b01, 3'b010, 5'd7, 32'h0000_0100, 32'h807F_F1A2, 32'h0,       1'b1, 5'd7, 32'h807F_F1A2, 1'b1, 64'd6};
    vecs[6]  = '{"lw_f3_011",1'b1, 1'b1, 2'b01, 3'b011, 5'd7, 32'h0000_0101, 32'h807F_F1A2, 32'h0,       1'b1, 5'd7, 32'h807F_F1A2, 1'b1, 64'd7};
    vecs[7]  = '{"jal",      1'b1, 1'b1, 2'b10, 3'b000, 5'd1, 32'h0000_0200, 32'h0,        32'h0000_0040, 1'b1, 5'd1, 32'h0000_0040, 1'b1, 64'd8};
    vecs[8]  = '{"jal_x0",   1'b1, 1'b1, 2'b10, 3'b000, 5'd0, 32'h0000_0200, 32'h0,        32'h0000_0040, 1'b0, 5'd0, 32'h0000_0040, 1'b1, 64'd9};
    vecs[9]  = '{"bubble",   1'b0, 1'b1, 2'b00, 3'b000, 5'd7, 32'h0000_0055, 32'h0,        32'h0,        1'b0, 5'd7, 32'h0000_0055, 1'b0, 64'd9};
    vecs[10] = '{"src_11",   1'b1, 1'b1, 2'b11, 3'b000, 5'd8, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_0044, 1'b1, 5'd8, 32'h0000_0000, 1'b1, 64'd10};
    vecs[11] = '{"lb_102",   1'b1, 1'b1, 2'b01, 3'b000, 5'd9, 32'h0000_0102, 32'h807F_F1A2, 32'h0,       1'b1, 5'd9, 32'h0000_007F, 1'b1, 64'd11};
    vecs[12] = '{"lh_100",   1'b1, 1'b1, 2'b01, 3'b001, 5'd10,32'h0000_0100, 32'h807F_F1A2, 32'h0,       1'b1, 5'd10,32'hFFFF_F1A2, 1'b1, 64'd12};
    vecs[13] = '{"no_rw",    1'b1, 1'b0, 2'b00, 3'b000, 5'd11,32'h0000_00AA, 32'h0,        32'h0,        1'b0, 5'd11,32'h0000_00AA, 1'b1, 64'd13};

    rst       = 1'b1;
    stall_w_i = 1'b0;
    flush_w_i = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Reset state, held across an edge with live inputs.
    step();
    check_all("reset", 1'b0, 5'd0, 32'h0, 1'b0, 64'd0);
    rst = 1'b0;

    // Table-driven vectors: each loads in one edge.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].valid, vecs[i].rw, vecs[i].src, vecs[i].f3, vecs[i].rd,
            vecs[i].alu, vecs[i].rdata, vecs[i].pc4);
      step();
      $display("[TB] vec %s: rw=%0b rd=%0d result=0x%08h valid=%0b instret=%0d",
               vecs[i].name, reg_write_w_o, rd_w_o, result_w_o, valid_w_o, instret_o);
      check_all(vecs[i].name, vecs[i].exp_rw, vecs[i].exp_rd, vecs[i].exp_res,
                vecs[i].exp_valid, vecs[i].exp_instret);
    end

    // Stall for 3 cycles while M inputs change: outputs and counter frozen.
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd12, 32'h1111_1111, 32'h0, 32'h0);
    step();
    $display("[TB] pre-stall load: result=0x%08h instret=%0d", result_w_o, instret_o);
    check_all("prestall", 1'b1, 5'd12, 32'h1111_1111, 1'b1, 64'd14);
    stall_w_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 2'b10, 3'b001, 5'(13 + c), 32'h2222_0000 + 32'(c), 32'h0, 32'h0000_0100);
      step();
      $display("[TB] stall cycle %0d: result=0x%08h instret=%0d", c, result_w_o, instret_o);
      check_all("stall", 1'b1, 5'd12, 32'h1111_1111, 1'b1, 64'd14);
    end
    // Release: the instruction held in M retires exactly once.
    stall_w_i = 1'b0;
    step();
    $display("[TB] stall release: rd=%0d result=0x%08h instret=%0d", rd_w_o, result_w_o, instret_o);
    check_all("unstall", 1'b1, 5'd15, 32'h0000_0100, 1'b1, 64'd15);

    // Flush together with stall: bubble loaded, not counted.
    flush_w_i = 1'b1;
    stall_w_i = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd16, 32'h3333_3333, 32'h0, 32'h0);
    step();
    $display("[TB] flush+stall: valid=%0b rw=%0b instret=%0d", valid_w_o, reg_write_w_o, instret_o);
    check("flush_stall.valid", {63'd0, valid_w_o}, 64'd0);
    check("flush_stall.reg_write", {63'd0, reg_write_w_o}, 64'd0);
    check("flush_stall.instret", instret_o, 64'd15);
    stall_w_i = 1'b0;
    step();
    $display("[TB] flush only: valid=%0b instret=%0d", valid_w_o, instret_o);
    check("flush.valid", {63'd0, valid_w_o}, 64'd0);
    check("flush.instret", instret_o, 64'd15);
    flush_w_i = 1'b0;

    // Asynchronous reset mid-operation.
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 32'h0);
    stall_w_i = 1'b1;
    step();
    stall_w_i = 1'b0;
    // The stall above held W, so load the ADD now.
    step();
    check_all("add_rd5", 1'b1, 5'd5, 32'h0000_1234, 1'b1, 64'd16);
    #2;
    rst = 1'b1;
    #1;
    $display("[TB] async reset: rw=%0b rd=%0d result=0x%08h valid=%0b instret=%0d",
             reg_write_w_o, rd_w_o, result_w_o, valid_w_o, instret_o);
    check_all("async_rst", 1'b0, 5'd0, 32'h0, 1'b0, 64'd0);
    stall_w_i = 1'b1;
    step();
    rst = 1'b0;
    stall_w_i = 1'b0;
    step();
    check_all("post_rst", 1'b1, 5'd5, 32'h0000_1234, 1'b1, 64'd1);

    // Counter wrap from all-ones.
    force dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_reg;
    check("wrap.preset", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd2, 32'h0000_0777, 32'h0, 32'h0);
    step();
    $display("[TB] wrap: instret=0x%016h", instret_o);
    check("wrap.instret", instret_o, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
